// File: rtl/univ_reg_sr.sv
// Universal register: parallel load, logical shifts, rotates, arithmetic shift right
// and synchronous clear. It has serial in/out and flags for zero and sign.
// Q and sout are registered. zero and msb are decoded from Q.

module univ_reg_sr #(
    parameter int unsigned       WIDTH   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             zero,
    output logic             msb
);

    // Operation encoding on the mode input
    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeLoad = 3'b001,
        ModeShl  = 3'b010,
        ModeShr  = 3'b011,
        ModeRol  = 3'b100,
        ModeRor  = 3'b101,
        ModeAsr  = 3'b110,
        ModeClr  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    mode_e            mode_op;

    assign mode_op = mode_e'(mode);

    // Next-state decode. Enable gates every mode, and HOLD covers any encoding that is not defined.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (en) begin
            case (mode_op)
                ModeHold: begin
                    q_d    = q_q;
                    sout_d = sout_q;
                end
                ModeLoad: begin
                    q_d    = D;
                    sout_d = sout_q;
                end
                ModeShl: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                end
                ModeShr: begin
                    q_d    = {sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                ModeRol: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                ModeRor: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                ModeAsr: begin
                    q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                ModeClr: begin
                    q_d    = '0;
                    sout_d = 1'b0;
                end
                default: begin
                    q_d    = q_q;
                    sout_d = sout_q;
                end
            endcase
        end
    end

    // State register. Synchronous reset discards any operation requested in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_VAL;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    // Flags are decoded from the current contents and are not registered separately.
    always_comb begin
        Q    = q_q;
        sout = sout_q;
        zero = (q_q == '0);
        msb  = q_q[WIDTH-1];
    end

endmodule

// File: tb/tb_univ_reg_sr.sv
// Directed bench for univ_reg_sr, with WIDTH=8 and RST_VAL=8'hA5.

module tb_univ_reg_sr;

    localparam int unsigned W = 8;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011,
                           ROL = 3'b100, ROR = 3'b101, ASR = 3'b110, CLR = 3'b111;

    logic         clk = 1'b0;
    logic         rst, en, sin;
    logic [2:0]   mode;
    logic [W-1:0] D, Q;
    logic         sout, zero, msb;

    int passed = 0;
    int total  = 0;

    univ_reg_sr #(
        .WIDTH   (W),
        .RST_VAL (8'hA5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .D    (D),
        .sin  (sin),
        .Q    (Q),
        .sout (sout),
        .zero (zero),
        .msb  (msb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive the inputs, wait for one rising edge, and then sample 1 time unit after that edge.
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [W-1:0] d, input logic s);
        rst = r; en = e; mode = m; D = d; sin = s;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ror_sout_exp;

    initial begin
        rst = 1'b1; en = 1'b1; mode = LOAD; D = 8'hFF; sin = 1'b0;
        #1;

        // Reset wins over LOAD for two edges
        step(1, 1, LOAD, 8'hFF, 0);
        step(1, 1, LOAD, 8'hFF, 0);
        check("rst_q", Q, 8'hA5);
        check("rst_sout", sout, 0);
        check("rst_zero", zero, 0);
        check("rst_msb", msb, 1);

        // Load, then hold with en=0
        step(0, 1, LOAD, 8'h3C, 0);
        check("load_q", Q, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, LOAD, 8'hFF, 1);
            check("en0_hold_q", Q, 8'h3C);
        end
        step(0, 1, HOLD, 8'hFF, 1);
        check("hold_q", Q, 8'h3C);

        // Serial shifts
        step(0, 1, LOAD, 8'h81, 0);
        step(0, 1, SHL, 8'h00, 0);
        check("shl_q", Q, 8'h02);
        check("shl_sout", sout, 1);
        step(0, 1, SHR, 8'h00, 1);
        check("shr_q", Q, 8'h81);
        check("shr_sout", sout, 0);

        // Rotate right a full turn
        ror_sout_exp = 8'b1001_0110;  // sout sequence is LSB first: 0,1,1,0,1,0,0,1
        step(0, 1, LOAD, 8'h96, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, ROR, 8'h00, 0);
            check("ror_sout", sout, ror_sout_exp[i]);
        end
        check("ror_q", Q, 8'h96);

        // Arithmetic shift right saturates a negative value at all ones
        step(0, 1, LOAD, 8'h80, 0);
        for (int i = 0; i < 7; i++) step(0, 1, ASR, 8'h00, 0);
        check("asr_q", Q, 8'hFF);
        check("asr_msb", msb, 1);
        step(0, 1, LOAD, 8'h40, 0);
        for (int i = 0; i < 7; i++) step(0, 1, ASR, 8'h00, 1);
        check("asr_pos_q", Q, 8'h00);

        // Clear, then check the flags
        step(0, 1, LOAD, 8'h01, 0);
        step(0, 1, CLR, 8'hFF, 1);
        check("clr_q", Q, 8'h00);
        check("clr_sout", sout, 0);
        check("clr_zero", zero, 1);
        step(0, 1, SHL, 8'h00, 1);
        check("shl1_q", Q, 8'h01);
        check("shl1_zero", zero, 0);

        // Reset in the middle of a ROL sequence
        step(0, 1, LOAD, 8'h0F, 0);
        step(0, 1, ROL, 8'h00, 0);
        check("rol1_q", Q, 8'h1E);
        step(0, 1, ROL, 8'h00, 0);
        check("rol2_q", Q, 8'h3C);
        step(1, 1, ROL, 8'h00, 0);
        check("midrst_q", Q, 8'hA5);
        check("midrst_sout", sout, 0);
        step(0, 1, ROL, 8'h00, 0);
        check("rol_after_q", Q, 8'h4B);
        check("rol_after_sout", sout, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
